// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: validates NEC frames and repeat strobes, then edits a six-digit BCD value.
// Optional: define IR_CMD_CTRL_ERR_CNT_EN to add o_err_cnt, a saturating rejected-frame counter.
module ir_cmd_ctrl #(
    parameter logic [7:0]  P_ADDR    = 8'h00,
    parameter logic [31:0] P_RPT_TMO = 32'd5_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_frame_vld,
    input  logic [31:0] i_frame,
    input  logic        i_repeat,
    output logic [23:0] o_value,
    output logic [23:0] o_edit,
    output logic        o_edit_act,
    output logic [7:0]  o_cmd,
    output logic        o_cmd_vld,
    output logic        o_err,
`ifdef IR_CMD_CTRL_ERR_CNT_EN
    output logic [7:0]  o_err_cnt,
`endif
    output logic        o_busy
);

    localparam logic [7:0] C_DIGIT_MAX = 8'h09;
    localparam logic [7:0] C_CLEAR     = 8'h10;
    localparam logic [7:0] C_ENTER     = 8'h11;
    localparam logic [7:0] C_INC       = 8'h12;
    localparam logic [7:0] C_DEC       = 8'h13;

    typedef enum logic [1:0] {StIdle, StCheck, StExec, StHold} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_frame;
    logic [23:0] r_value;
    logic [23:0] r_edit;
    logic        r_edit_act;
    logic [7:0]  r_cmd;
    logic        r_cmd_vld;
    logic        r_err;
    logic [31:0] r_tmr;
    logic        r_rpt_arm;

    logic [7:0]  w_cmd;
    logic        w_legal;
    logic        w_frame_ok;
    logic        w_exec;
    logic        w_step;
    logic        w_is_digit;
    logic        w_reject;

    function automatic logic [23:0] f_bcd_inc(input logic [23:0] v);
        logic [23:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (c) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [23:0] f_bcd_dec(input logic [23:0] v);
        logic [23:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (b) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    b = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // A repeat reuses r_frame: while armed, it still holds the INC/DEC frame that armed it.
    assign w_cmd      = r_frame[15:8];
    assign w_is_digit = (w_cmd <= C_DIGIT_MAX);
    assign w_legal    = w_is_digit || ((w_cmd >= C_CLEAR) && (w_cmd <= C_DEC));
    assign w_frame_ok = (r_frame[31:24] == P_ADDR) && (r_frame[31:24] == ~r_frame[23:16])
                        && (w_cmd == ~r_frame[7:0]) && w_legal;
    assign w_exec     = (r_state == StExec);
    assign w_step     = (w_cmd == C_INC) || (w_cmd == C_DEC);
    assign w_reject   = (r_state == StCheck) && !w_frame_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (i_frame_vld) begin
                    w_state_nxt = StCheck;
                end else if (i_repeat && r_rpt_arm) begin
                    w_state_nxt = StExec;
                end
            end
            StCheck: w_state_nxt = w_frame_ok ? StExec : StIdle;
            StExec:  w_state_nxt = w_step ? StHold : StIdle;
            StHold:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_value    <= '0;
            r_edit     <= '0;
            r_edit_act <= 1'b0;
            r_cmd      <= '0;
            r_cmd_vld  <= 1'b0;
            r_err      <= 1'b0;
            r_tmr      <= '0;
            r_rpt_arm  <= 1'b0;
        end else begin
            r_cmd_vld <= 1'b0;
            r_err     <= 1'b0;

            if ((r_state == StIdle) && i_frame_vld) begin
                r_frame <= i_frame;
            end

            if (w_exec) begin
                r_cmd     <= w_cmd;
                r_cmd_vld <= 1'b1;
                if (w_is_digit) begin
                    r_edit     <= {r_edit[19:0], w_cmd[3:0]};
                    r_edit_act <= 1'b1;
                end else begin
                    case (w_cmd)
                        C_CLEAR: begin
                            r_edit     <= '0;
                            r_edit_act <= 1'b0;
                        end
                        C_ENTER: begin
                            if (r_edit_act) begin
                                r_value <= r_edit;
                            end
                            r_edit     <= '0;
                            r_edit_act <= 1'b0;
                        end
                        C_INC:   r_value <= f_bcd_inc(r_value);
                        C_DEC:   r_value <= f_bcd_dec(r_value);
                        default: ;
                    endcase
                end
            end

            // Repeat window: reloaded by every executed INC/DEC, whether from a frame or a repeat.
            if (w_exec && w_step) begin
                r_tmr     <= P_RPT_TMO;
                r_rpt_arm <= (P_RPT_TMO != 32'd0);
            end else if (w_exec) begin
                r_tmr     <= '0;
                r_rpt_arm <= 1'b0;
            end else if (r_tmr != 32'd0) begin
                r_tmr <= r_tmr - 32'd1;
                if (r_tmr == 32'd1) begin
                    r_rpt_arm <= 1'b0;
                end
            end

            if (w_reject) begin
                r_err     <= 1'b1;
                r_rpt_arm <= 1'b0;
            end
        end
    end

`ifdef IR_CMD_CTRL_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (w_reject && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign o_err_cnt = r_err_cnt;
`endif

    assign o_value    = r_value;
    assign o_edit     = r_edit;
    assign o_edit_act = r_edit_act;
    assign o_cmd      = r_cmd;
    assign o_cmd_vld  = r_cmd_vld;
    assign o_err      = r_err;
    assign o_busy     = (r_state != StIdle);

endmodule

// File: tb/tb_ir_cmd_ctrl.sv
// tb_ir_cmd_ctrl: vector table, hand-written corner sequences and a randomized run against a
// decimal reference model of ir_cmd_ctrl (short repeat timeout for simulation).
module tb_ir_cmd_ctrl;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_frame_vld = 1'b0;
    logic [31:0] i_frame = '0;
    logic        i_repeat = 1'b0;
    logic [23:0] o_value;
    logic [23:0] o_edit;
    logic        o_edit_act;
    logic [7:0]  o_cmd;
    logic        o_cmd_vld;
    logic        o_err;
    logic        o_busy;
`ifdef IR_CMD_CTRL_ERR_CNT_EN
    logic [7:0]  o_err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    ir_cmd_ctrl #(
        .P_ADDR    (8'h00),
        .P_RPT_TMO (32'(TMO))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_frame_vld (i_frame_vld),
        .i_frame     (i_frame),
        .i_repeat    (i_repeat),
        .o_value     (o_value),
        .o_edit      (o_edit),
        .o_edit_act  (o_edit_act),
        .o_cmd       (o_cmd),
        .o_cmd_vld   (o_cmd_vld),
        .o_err       (o_err),
`ifdef IR_CMD_CTRL_ERR_CNT_EN
        .o_err_cnt   (o_err_cnt),
`endif
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rpt;
        logic [31:0] frame;
        bit          err;
        bit          vld;
        logic [23:0] value;
        logic [23:0] edit;
        bit          act;
        logic [7:0]  cmd;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit rpt, input logic [31:0] frame, input bit err, input bit vld,
                       input logic [23:0] value, input logic [23:0] edit, input bit act,
                       input logic [7:0] cmd);
        vec_t v;
        v = '{rpt, frame, err, vld, value, edit, act, cmd};
        vecs.push_back(v);
    endtask

    // Launches one strobe and checks pulse timing, then the settled registers.
    task automatic apply(input string tag, input vec_t v);
        if (v.rpt) begin
            i_repeat = 1'b1;
        end else begin
            i_frame_vld = 1'b1;
            i_frame     = v.frame;
        end
        tick();
        i_repeat    = 1'b0;
        i_frame_vld = 1'b0;
        chk({tag, " busy"}, 32'(o_busy), 32'(!(v.rpt && !v.vld)));
        tick();
        if (v.rpt) begin
            chk({tag, " vld"}, 32'(o_cmd_vld), 32'(v.vld));
            chk({tag, " err"}, 32'(o_err), 32'd0);
        end else begin
            chk({tag, " err"}, 32'(o_err), 32'(v.err));
            chk({tag, " early vld"}, 32'(o_cmd_vld), 32'd0);
        end
        tick();
        if (v.rpt) begin
            chk({tag, " vld pulse"}, 32'(o_cmd_vld), 32'd0);
        end else begin
            chk({tag, " vld"}, 32'(o_cmd_vld), 32'(v.vld));
            chk({tag, " err pulse"}, 32'(o_err), 32'd0);
        end
        tick();
        tick();
        chk({tag, " value"}, 32'(o_value), 32'(v.value));
        chk({tag, " edit"}, 32'(o_edit), 32'(v.edit));
        chk({tag, " act"}, 32'(o_edit_act), 32'(v.act));
        chk({tag, " cmd"}, 32'(o_cmd), 32'(v.cmd));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " value"}, 32'(o_value), 32'd0);
        chk({tag, " edit"}, 32'(o_edit), 32'd0);
        chk({tag, " act"}, 32'(o_edit_act), 32'd0);
        chk({tag, " cmd"}, 32'(o_cmd), 32'd0);
        chk({tag, " vld"}, 32'(o_cmd_vld), 32'd0);
        chk({tag, " err"}, 32'(o_err), 32'd0);
        chk({tag, " busy"}, 32'(o_busy), 32'd0);
`ifdef IR_CMD_CTRL_ERR_CNT_EN
        chk({tag, " err_cnt"}, 32'(o_err_cnt), 32'd0);
`endif
    endtask

    function automatic int bcd2int(input logic [23:0] b);
        int r = 0;
        for (int i = 5; i >= 0; i--) r = r * 10 + int'(b[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [23:0] int2bcd(input int v);
        logic [23:0] r = '0;
        int          t = v;
        for (int i = 0; i < 6; i++) begin
            r[i*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_cmd_vld) cnt++;
        end
    endtask

    initial begin
        vec_t v;
        int   cnt;
        // reference model state
        int   m_value, m_edit, m_errs;
        bit   m_act, m_armed;
        logic [7:0] m_cmd;
        int unsigned m_last;

        do_reset();
        chk_zero("reset");

        add(0, 32'h00FF01FE, 0, 1, 24'h000000, 24'h000001, 1, 8'h01);
        add(0, 32'h00FF02FD, 0, 1, 24'h000000, 24'h000012, 1, 8'h02);
        add(0, 32'h00FF03FC, 0, 1, 24'h000000, 24'h000123, 1, 8'h03);
        add(0, 32'h00FF11EE, 0, 1, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h00FF11EE, 0, 1, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h00FF05FB, 1, 0, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h01FE05FA, 1, 0, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h00FF20DF, 1, 0, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h00FE01FE, 1, 0, 24'h000123, 24'h000000, 0, 8'h11);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h000009, 1, 8'h09);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h000099, 1, 8'h09);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h000999, 1, 8'h09);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h009999, 1, 8'h09);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h099999, 1, 8'h09);
        add(0, 32'h00FF09F6, 0, 1, 24'h000123, 24'h999999, 1, 8'h09);
        add(0, 32'h00FF11EE, 0, 1, 24'h999999, 24'h000000, 0, 8'h11);
        add(0, 32'h00FF12ED, 0, 1, 24'h000000, 24'h000000, 0, 8'h12);
        add(0, 32'h00FF13EC, 0, 1, 24'h999999, 24'h000000, 0, 8'h13);
        add(1, 32'h0,        0, 1, 24'h999998, 24'h000000, 0, 8'h13);
        add(0, 32'h00FF07F8, 0, 1, 24'h999998, 24'h000007, 1, 8'h07);
        add(1, 32'h0,        0, 0, 24'h999998, 24'h000007, 1, 8'h07);
        add(0, 32'h00FF01FE, 0, 1, 24'h999998, 24'h000071, 1, 8'h01);
        add(0, 32'h00FF02FD, 0, 1, 24'h999998, 24'h000712, 1, 8'h02);
        add(0, 32'h00FF03FC, 0, 1, 24'h999998, 24'h007123, 1, 8'h03);
        add(0, 32'h00FF04FB, 0, 1, 24'h999998, 24'h071234, 1, 8'h04);
        add(0, 32'h00FF05FA, 0, 1, 24'h999998, 24'h712345, 1, 8'h05);
        add(0, 32'h00FF06F9, 0, 1, 24'h999998, 24'h123456, 1, 8'h06);
        add(0, 32'h00FF10EF, 0, 1, 24'h999998, 24'h000000, 0, 8'h10);

        for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);
`ifdef IR_CMD_CTRL_ERR_CNT_EN
        chk("table err_cnt", 32'(o_err_cnt), 32'd4);
`endif

        // Repeats inside the window execute; one long after it is ignored.
        apply("rptA inc", '{0, 32'h00FF12ED, 0, 1, 24'h999999, 24'h0, 0, 8'h12});
        repeat (15) tick();
        apply("rptA r1", '{1, 32'h0, 0, 1, 24'h000000, 24'h0, 0, 8'h12});
        repeat (15) tick();
        apply("rptA r2", '{1, 32'h0, 0, 1, 24'h000001, 24'h0, 0, 8'h12});
        repeat (100) tick();
        apply("rptA late", '{1, 32'h0, 0, 0, 24'h000001, 24'h0, 0, 8'h12});

        // Frame and repeat together while armed: only the frame executes.
        apply("both inc", '{0, 32'h00FF12ED, 0, 1, 24'h000002, 24'h0, 0, 8'h12});
        i_frame_vld = 1'b1;
        i_frame     = 32'h00FF04FB;
        i_repeat    = 1'b1;
        tick();
        i_frame_vld = 1'b0;
        i_repeat    = 1'b0;
        count_pulses(8, cnt);
        chk("both pulses", 32'(cnt), 32'd1);
        chk("both value", 32'(o_value), 32'h000002);
        chk("both edit", 32'(o_edit), 32'h000004);

        // Second frame during CHECK is dropped.
        i_frame_vld = 1'b1;
        i_frame     = 32'h00FF05FA;
        tick();
        chk("drop busy", 32'(o_busy), 32'd1);
        i_frame = 32'h00FF08F7;
        tick();
        i_frame_vld = 1'b0;
        count_pulses(7, cnt);
        chk("drop pulses", 32'(cnt), 32'd1);
        chk("drop edit", 32'(o_edit), 32'h000045);
        chk("drop cmd", 32'(o_cmd), 32'h05);

        // Reset during the EXEC cycle of ENTER.
        i_frame_vld = 1'b1;
        i_frame     = 32'h00FF11EE;
        tick();
        i_frame_vld = 1'b0;
        tick();
        chk("rstx busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("rstx");
        tick();
        rst_n = 1'b1;
        tick();
        apply("rstx after", '{0, 32'h00FF03FC, 0, 1, 24'h000000, 24'h000003, 1, 8'h03});

        // Randomized run against a decimal model.
        do_reset();
        m_value = 0; m_edit = 0; m_errs = 0; m_act = 0; m_armed = 0; m_cmd = 8'h00; m_last = 0;
        for (int t = 0; t < 150; t++) begin
            int unsigned s;
            int          sel;
            logic [7:0]  c;
            bit          ok;
            s = cyc + 1;  // edge that samples the strobe
            v.rpt = ($urandom_range(0, 99) < 30);
            if (v.rpt) begin
                v.frame = '0;
                v.err   = 0;
                v.vld   = m_armed && ((s - m_last) <= TMO);
                if (v.vld) begin
                    m_value = (m_cmd == 8'h12) ? (m_value + 1) % 1000000
                                               : (m_value + 999999) % 1000000;
                    m_last  = s + 1;
                end
            end else begin
                sel = int'($urandom_range(0, 99));
                if (sel < 40)      c = 8'h12 + 8'($urandom_range(0, 1));
                else if (sel < 70) c = 8'($urandom_range(0, 9));
                else if (sel < 80) c = 8'h10 + 8'($urandom_range(0, 1));
                else               c = 8'h14 + 8'($urandom_range(0, 200));
                v.frame = {8'h00, 8'hFF, c, ~c};
                if ($urandom_range(0, 6) == 0) v.frame = v.frame ^ (32'h1 << $urandom_range(0, 31));
                c  = v.frame[15:8];
                ok = (v.frame[31:24] == 8'h00) && (v.frame[23:16] == 8'hFF)
                     && (v.frame[7:0] == ~c) && ((c <= 8'd9) || (c >= 8'h10 && c <= 8'h13));
                v.err = !ok;
                v.vld = ok;
                if (!ok) begin
                    m_armed = 0;
                    if (m_errs < 255) m_errs++;
                end else begin
                    m_cmd   = c;
                    m_armed = (c == 8'h12) || (c == 8'h13);
                    if (c <= 8'd9) begin
                        m_edit = (m_edit * 10 + int'(c)) % 1000000;
                        m_act  = 1;
                    end else if (c == 8'h10) begin
                        m_edit = 0;
                        m_act  = 0;
                    end else if (c == 8'h11) begin
                        if (m_act) m_value = m_edit;
                        m_edit = 0;
                        m_act  = 0;
                    end else begin
                        m_value = (c == 8'h12) ? (m_value + 1) % 1000000
                                               : (m_value + 999999) % 1000000;
                        m_last  = s + 2;
                    end
                end
            end
            v.value = int2bcd(m_value);
            v.edit  = int2bcd(m_edit);
            v.act   = m_act;
            v.cmd   = m_cmd;
            apply($sformatf("rnd%0d", t), v);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 8)) tick();
            else repeat ($urandom_range(TMO + 10, TMO + 40)) tick();
        end
        chk("rnd value int", 32'(bcd2int(o_value)), 32'(m_value));
`ifdef IR_CMD_CTRL_ERR_CNT_EN
        chk("rnd err_cnt", 32'(o_err_cnt), 32'(m_errs));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
